// File: rtl/bcd_cnt_n_if.sv
// bcd_cnt_n_if: control and status bundle for one cascadable BCD counter stage.
//   ENABLE    master->slave  global count enable
//   CARRY_in  master->slave  count request from the lower stage
//   DOWN      master->slave  0 = count up, 1 = count down
//   LOAD      master->slave  synchronous load strobe
//   LOAD_VAL  master->slave  BCD value to load (4*DIGITS bits)
//   CNT       slave->master  current BCD count (4*DIGITS bits)
//   CARRY_out slave->master  combinational wrap indication for the next stage
//   LOAD_ERR  slave->master  one-cycle pulse after a rejected load
interface bcd_cnt_n_if #(
    parameter int DIGITS = 4
) ();
    logic                  ENABLE;
    logic                  CARRY_in;
    logic                  DOWN;
    logic                  LOAD;
    logic [4*DIGITS-1:0]   LOAD_VAL;
    logic [4*DIGITS-1:0]   CNT;
    logic                  CARRY_out;
    logic                  LOAD_ERR;
    modport master (
        output ENABLE, CARRY_in, DOWN, LOAD, LOAD_VAL,
        input  CNT, CARRY_out, LOAD_ERR
    );
    modport slave (
        input  ENABLE, CARRY_in, DOWN, LOAD, LOAD_VAL,
        output CNT, CARRY_out, LOAD_ERR
    );
endinterface

// File: rtl/bcd_cnt_n.sv
// bcd_cnt_n: N-digit cascadable BCD counter with MIN/MAX wrap, up/down and validated load.
//   CLK    rising-edge clock
//   RESET  asynchronous active-high reset, loads RESET_VAL
//   bus    bcd_cnt_n_if.slave: ENABLE, CARRY_in, DOWN, LOAD, LOAD_VAL in;
//          CNT, CARRY_out, LOAD_ERR out
module bcd_cnt_n #(
    parameter int                  DIGITS    = 4,
    parameter logic [4*DIGITS-1:0] MIN_VAL   = 16'h0000,
    parameter logic [4*DIGITS-1:0] MAX_VAL   = 16'h2099,
    parameter logic [4*DIGITS-1:0] RESET_VAL = 16'h2000
) (
    input  logic         CLK,
    input  logic         RESET,
    bcd_cnt_n_if.slave   bus
);
    localparam int W = 4 * DIGITS;

    logic [W-1:0] cnt_q, cnt_d, cnt_inc, cnt_dec;
    logic         load_err_q, load_err_d;
    logic         at_max, at_min, step, load_ok;

    // Decimal ripple increment: a 9 rolls to 0 and passes the +1 upward.
    function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
        logic c;
        bcd_inc = v;
        c = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            bcd_inc[4*k+:4] = c ? ((v[4*k+:4] == 4'd9) ? 4'd0 : v[4*k+:4] + 4'd1) : v[4*k+:4];
            c = c & (v[4*k+:4] == 4'd9);
        end
    endfunction

    // Decimal ripple decrement: a 0 rolls to 9 and passes the -1 upward.
    function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
        logic b;
        bcd_dec = v;
        b = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            bcd_dec[4*k+:4] = b ? ((v[4*k+:4] == 4'd0) ? 4'd9 : v[4*k+:4] - 4'd1) : v[4*k+:4];
            b = b & (v[4*k+:4] == 4'd0);
        end
    endfunction

    function automatic logic digits_ok(input logic [W-1:0] v);
        digits_ok = 1'b1;
        for (int k = 0; k < DIGITS; k++)
            digits_ok = digits_ok & (v[4*k+:4] <= 4'd9);
    endfunction

    always_comb begin
        at_max     = cnt_q == MAX_VAL;
        at_min     = cnt_q == MIN_VAL;
        step       = bus.ENABLE & bus.CARRY_in & ~bus.LOAD;
        // With every nibble <= 9, binary ordering equals decimal ordering.
        load_ok    = digits_ok(bus.LOAD_VAL) && bus.LOAD_VAL >= MIN_VAL && bus.LOAD_VAL <= MAX_VAL;
        cnt_inc    = at_max ? MIN_VAL : bcd_inc(cnt_q);
        cnt_dec    = at_min ? MAX_VAL : bcd_dec(cnt_q);
        cnt_d      = bus.LOAD ? (load_ok ? bus.LOAD_VAL : cnt_q)
                   : step     ? (bus.DOWN ? cnt_dec : cnt_inc)
                   :            cnt_q;
        load_err_d = bus.LOAD & ~load_ok;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            cnt_q      <= RESET_VAL;
            load_err_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            load_err_q <= load_err_d;
        end
    end

    assign bus.CNT       = cnt_q;
    assign bus.LOAD_ERR  = load_err_q;
    // Held low in reset so a stage at its bound cannot ripple into the next one.
    assign bus.CARRY_out = ~RESET & step & (bus.DOWN ? at_min : at_max);
endmodule

// File: tb/tb_bcd_cnt_n.sv
// tb_bcd_cnt_n: checks three counter configurations (year 0000-2099, seconds 00-59, month 01-12) against a decimal model.
module tb_bcd_cnt_n;
    logic        clk = 1'b0;
    bit          rst;
    logic        en, cin, dn, ld;
    logic [15:0] lv;
    int          vecs = 0;
    int          errs = 0;

    localparam int DIG [3]  = '{4, 2, 2};
    localparam int MINV [3] = '{0, 0, 1};
    localparam int MAXV [3] = '{2099, 59, 12};
    localparam int RSTV [3] = '{2000, 30, 6};

    int mv [3]   = '{2000, 30, 6};
    bit merr [3] = '{0, 0, 0};

    bcd_cnt_n_if #(.DIGITS(4)) b0 ();
    bcd_cnt_n_if #(.DIGITS(2)) b1 ();
    bcd_cnt_n_if #(.DIGITS(2)) b2 ();

    bcd_cnt_n #(.DIGITS(4), .MIN_VAL(16'h0000), .MAX_VAL(16'h2099), .RESET_VAL(16'h2000))
        u0 (.CLK(clk), .RESET(rst), .bus(b0));
    bcd_cnt_n #(.DIGITS(2), .MIN_VAL(8'h00), .MAX_VAL(8'h59), .RESET_VAL(8'h30))
        u1 (.CLK(clk), .RESET(rst), .bus(b1));
    bcd_cnt_n #(.DIGITS(2), .MIN_VAL(8'h01), .MAX_VAL(8'h12), .RESET_VAL(8'h06))
        u2 (.CLK(clk), .RESET(rst), .bus(b2));

    assign b0.ENABLE = en;  assign b0.CARRY_in = cin; assign b0.DOWN = dn; assign b0.LOAD = ld; assign b0.LOAD_VAL = lv;
    assign b1.ENABLE = en;  assign b1.CARRY_in = cin; assign b1.DOWN = dn; assign b1.LOAD = ld; assign b1.LOAD_VAL = lv[7:0];
    assign b2.ENABLE = en;  assign b2.CARRY_in = cin; assign b2.DOWN = dn; assign b2.LOAD = ld; assign b2.LOAD_VAL = lv[7:0];

    logic [15:0] gc [3];
    logic        gco [3];
    logic        ge [3];
    assign gc[0] = b0.CNT;            assign gco[0] = b0.CARRY_out; assign ge[0] = b0.LOAD_ERR;
    assign gc[1] = {8'h00, b1.CNT};   assign gco[1] = b1.CARRY_out; assign ge[1] = b1.LOAD_ERR;
    assign gc[2] = {8'h00, b2.CNT};   assign gco[2] = b2.CARRY_out; assign ge[2] = b2.LOAD_ERR;

    always #5 clk = ~clk;

    function automatic logic [15:0] to_bcd(input int v);
        int x = v;
        to_bcd = '0;
        for (int k = 0; k < 4; k++) begin
            to_bcd[4*k+:4] = 4'(x % 10);
            x = x / 10;
        end
    endfunction

    function automatic bit from_bcd(input logic [15:0] b, input int dig, output int v);
        from_bcd = 1'b1;
        v = 0;
        for (int k = dig - 1; k >= 0; k--) begin
            if (b[4*k+:4] > 4'd9) from_bcd = 1'b0;
            v = v * 10 + int'(b[4*k+:4]);
        end
    endfunction

    task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    // Decimal reference: values kept as integers, wrap and load rules applied directly.
    always @(posedge clk or posedge rst) begin
        for (int i = 0; i < 3; i++) begin
            int  v;
            bit  ok;
            if (rst) begin
                mv[i]   = RSTV[i];
                merr[i] = 1'b0;
            end else if (ld) begin
                ok = from_bcd(lv, DIG[i], v);
                if (ok && v >= MINV[i] && v <= MAXV[i]) begin
                    mv[i]   = v;
                    merr[i] = 1'b0;
                end else merr[i] = 1'b1;
            end else begin
                merr[i] = 1'b0;
                if (en && cin)
                    mv[i] = dn ? ((mv[i] == MINV[i]) ? MAXV[i] : mv[i] - 1)
                               : ((mv[i] == MAXV[i]) ? MINV[i] : mv[i] + 1);
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            bit ec;
            ec = !rst && en && cin && !ld && (dn ? mv[i] == MINV[i] : mv[i] == MAXV[i]);
            chk($sformatf("model_cnt%0d", i), gc[i], to_bcd(mv[i]));
            chk($sformatf("model_carry%0d", i), 16'(gco[i]), 16'(ec));
            chk($sformatf("model_err%0d", i), 16'(ge[i]), 16'(merr[i]));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit pat [5] = '{1, 0, 1, 1, 0};
        en = 0; cin = 0; dn = 0; ld = 0; lv = '0;
        rst = 1'b1;
        #1;
        chk("reset_cnt", b0.CNT, 16'h2000);
        chk("reset_err", 16'(b0.LOAD_ERR), 16'h0);
        tick; tick;
        rst = 1'b0;
        // up wrap with carry
        tick; ld = 1; lv = 16'h2098;
        tick; ld = 0; en = 1; cin = 1; dn = 0;
        #1 chk("wrap_pre", b0.CNT, 16'h2098);
        tick; #1 chk("wrap_max", b0.CNT, 16'h2099);
        chk("wrap_carry", 16'(b0.CARRY_out), 16'h1);
        tick; #1 chk("wrap_zero", b0.CNT, 16'h0000);
        chk("wrap_carry0", 16'(b0.CARRY_out), 16'h0);
        // digit ripple on seconds
        ld = 1; lv = 16'h0009;
        tick; ld = 0;
        #1 chk("sec_09", 16'(b1.CNT), 16'h0009);
        tick; #1 chk("sec_10", 16'(b1.CNT), 16'h0010);
        ld = 1; lv = 16'h0059;
        tick; ld = 0;
        #1 chk("sec_59", 16'(b1.CNT), 16'h0059);
        chk("sec_carry", 16'(b1.CARRY_out), 16'h1);
        tick; #1 chk("sec_00", 16'(b1.CNT), 16'h0000);
        // month down count
        ld = 1; lv = 16'h0010;
        tick; ld = 0; dn = 1;
        #1 chk("mon_10", 16'(b2.CNT), 16'h0010);
        tick; #1 chk("mon_09", 16'(b2.CNT), 16'h0009);
        ld = 1; lv = 16'h0001;
        tick; ld = 0;
        #1 chk("mon_01", 16'(b2.CNT), 16'h0001);
        chk("mon_borrow", 16'(b2.CARRY_out), 16'h1);
        tick; #1 chk("mon_12", 16'(b2.CNT), 16'h0012);
        // load validation (year is now 0000)
        dn = 0; en = 0; ld = 1; lv = 16'h20A0;
        tick; ld = 0;
        #1 chk("ld_hex_held", b0.CNT, 16'h0000);
        chk("ld_hex_err", 16'(b0.LOAD_ERR), 16'h1);
        tick; #1 chk("ld_err_pulse", 16'(b0.LOAD_ERR), 16'h0);
        ld = 1; lv = 16'h2150;
        tick; ld = 0;
        #1 chk("ld_range_err", 16'(b0.LOAD_ERR), 16'h1);
        chk("ld_range_held", b0.CNT, 16'h0000);
        ld = 1; lv = 16'h1999;
        tick; ld = 0;
        #1 chk("ld_ok", b0.CNT, 16'h1999);
        chk("ld_ok_err", 16'(b0.LOAD_ERR), 16'h0);
        // load wins over a same-cycle count request at the bound
        ld = 1; lv = 16'h2099;
        tick; en = 1; cin = 1; lv = 16'h1234;
        #1 chk("ld_vs_cnt_carry", 16'(b0.CARRY_out), 16'h0);
        tick; ld = 0; en = 0;
        #1 chk("ld_vs_cnt", b0.CNT, 16'h1234);
        // gating
        repeat (20) begin
            cin = 1'($urandom);
            tick;
        end
        #1 chk("gate_hold", b0.CNT, 16'h1234);
        en = 1;
        for (int i = 0; i < 5; i++) begin
            cin = pat[i];
            tick;
        end
        en = 0;
        #1 chk("gate_steps", b0.CNT, 16'h1237);
        // asynchronous reset mid-cycle at the bound
        ld = 1; lv = 16'h2099;
        tick; ld = 0; en = 1; cin = 1;
        #2 rst = 1;
        #1 chk("areset_cnt", b0.CNT, 16'h2000);
        chk("areset_carry", 16'(b0.CARRY_out), 16'h0);
        tick; tick;
        #1 chk("areset_hold", b0.CNT, 16'h2000);
        rst = 0;
        tick; #1 chk("areset_resume", b0.CNT, 16'h2001);
        // randomized traffic
        repeat (600) begin
            int sel = $urandom_range(0, 2);
            en  = ($urandom % 8) != 0;
            cin = ($urandom % 4) != 0;
            dn  = 1'($urandom);
            ld  = ($urandom % 8) == 0;
            lv  = (sel == 0) ? 16'($urandom)
                : (sel == 1) ? to_bcd($urandom_range(0, 2199))
                :              to_bcd($urandom_range(0, 99));
            rst = ($urandom % 100) == 0;
            tick;
        end
        rst = 0; ld = 0; en = 0;
        tick; tick;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/bcd_cnt_n.md
Name: bcd_cnt_n

Overview:
- Parametrised N-digit cascadable BCD counter. Generalises the fixed 3-digit year counter into one block for seconds, minutes, hours, days, months and years in the digital clock.
- Adds:
  - programmable MIN/MAX wrap bounds
  - up/down counting for time-setting
  - synchronous validated load
  - combinational carry/borrow for chaining
- Instances chain by wiring CARRY_out of one stage to CARRY_in of the next.

Parameters:
- DIGITS, 4, number of BCD digits; CNT width is 4*DIGITS (1..8).
- MIN_VAL, 16'h0000, lower wrap bound, BCD-encoded, width 4*DIGITS.
- MAX_VAL, 16'h2099, upper wrap bound, BCD-encoded, width 4*DIGITS; MIN_VAL ≤ MAX_VAL.
- RESET_VAL, 16'h2000, value loaded on RESET; must satisfy MIN_VAL ≤ RESET_VAL ≤ MAX_VAL.

Ports:
- CLK  in  1  system clock, rising edge.
- RESET  in  1  asynchronous, active-high reset.
- ENABLE  in  1  global count enable.
- CARRY_in  in  1  count request from the lower stage; tie high for the lowest stage.
- DOWN  in  1  0 = count up, 1 = count down.
- LOAD  in  1  synchronous load strobe.
- LOAD_VAL  in  4*DIGITS  BCD value to load.
- CNT  out  4*DIGITS  current count, BCD; digit k is CNT[4k+3:4k], digit 0 is least significant.
- CARRY_out  out  1  combinational wrap indication to the next stage.
- LOAD_ERR  out  1  registered one-cycle pulse when a load is rejected.

Behaviour:
- Reset (RESET=1, asynchronous):
  - CNT = RESET_VAL; LOAD_ERR = 0.
  - CARRY_out = 0, because it is combinational and ENABLE/CARRY_in do not qualify while the counter is held in reset.
  - Deasserting RESET mid-operation resumes counting from RESET_VAL on the next qualified edge.
- Priority at each CLK rising edge: RESET > LOAD > count > hold.
- Load (LOAD=1): independent of ENABLE and CARRY_in.
  - LOAD_VAL is valid when every nibble is ≤ 9 and MIN_VAL ≤ LOAD_VAL ≤ MAX_VAL.
  - Valid: CNT <= LOAD_VAL and LOAD_ERR <= 0.
  - Invalid: CNT is held and LOAD_ERR <= 1 for exactly one cycle.
  - Any count request in the same cycle is discarded.
- Count step, when LOAD=0, ENABLE=1 and CARRY_in=1:
  - Up (DOWN=0): if CNT == MAX_VAL, CNT <= MIN_VAL. Otherwise BCD increment: digit 0 +1; a digit at 9 goes to 0 and propagates +1 to the next digit.
  - Down (DOWN=1): if CNT == MIN_VAL, CNT <= MAX_VAL. Otherwise BCD decrement: a digit at 0 goes to 9 and propagates -1 to the next digit.
  - Arithmetic is per-nibble decimal. No binary intermediate may leave a nibble at A–F.
- Hold: otherwise CNT is unchanged. LOAD_ERR <= 0 on every non-rejected-load edge.
- CARRY_out (combinational, zero latency):
  - CARRY_out = ENABLE & CARRY_in & ~LOAD & (DOWN ? CNT==MIN_VAL : CNT==MAX_VAL).
  - It is asserted in the same cycle as the wrapping step, so the next stage updates on the same edge.
  - Chained stages share DOWN and ENABLE.
- The decimal boundary test is a full-vector compare against MAX_VAL/MIN_VAL. It must not be a partial compare on the upper digits.
- DOWN may change on any cycle and takes effect on the next edge. There is no internal state beyond CNT and LOAD_ERR.
- Out-of-range CNT is unreachable: reset and load are validated, and stepping stays within bounds.

Test Plan:
- Reset: assert RESET asynchronously mid-cycle with defaults → CNT=16'h2000 immediately; LOAD_ERR=0; CARRY_out=0 while RESET=1.
- Up wrap with carry: defaults, load 16'h2098, ENABLE=1, CARRY_in=1, DOWN=0.
  - After 1 edge CNT=16'h2099 and CARRY_out=1 in that cycle.
  - After the next edge CNT=16'h0000 and CARRY_out=0.
- Digit ripple, DIGITS=2, MIN_VAL=8'h00, MAX_VAL=8'h59, DOWN=0:
  - load 8'h09, 1 step → 8'h10.
  - load 8'h59, 1 step → 8'h00 with CARRY_out=1 before the edge.
- Down count and month bounds, DIGITS=2, MIN_VAL=8'h01, MAX_VAL=8'h12, DOWN=1:
  - CNT=8'h10, 1 step → 8'h09.
  - CNT=8'h01, 1 step → 8'h12 with CARRY_out=1.
- Load validation, defaults:
  - LOAD_VAL=16'h20A0 → CNT held and LOAD_ERR=1 for one cycle.
  - LOAD_VAL=16'h2150 → rejected.
  - LOAD_VAL=16'h1999 → accepted and LOAD_ERR=0.
  - LOAD and count request in the same cycle → loaded value wins and CARRY_out=0.
- Gating: CARRY_in toggling with ENABLE=0 for 20 cycles → CNT unchanged and CARRY_out=0. Re-enable → counts only on cycles where CARRY_in=1.
